alu_issue_stage: RTL

Execute-stage issue register that drives the ALU. It decodes RV32I/RV64I integer opcodes into an aluOperation and selects/forwards operand A and B. It registers the result into the ALUOp/ALUOpA/ALUOpB bundle, using a valid/ready handshake, stall hold and flush. It sits between the decode stage and the combinational ALU and is the initiator side of the ALU operation interface.

---
 rtl/alu_issue_stage.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes RV32I/RV64I integer ops, forwards operands from the
// Mem/Wb stages and registers the operation bundle behind a valid/ready handshake.

package alu_issue_pkg;
  // Encoding is part of the ALU operation interface; keep values stable.
  typedef enum logic [3:0] {
    AluAdd  = 4'd0,
    AluSub  = 4'd1,
    AluSll  = 4'd2,
    AluSlt  = 4'd3,
    AluSltu = 4'd4,
    AluXor  = 4'd5,
    AluSrl  = 4'd6,
    AluSra  = 4'd7,
    AluOr   = 4'd8,
    AluAnd  = 4'd9,
    AluSllw = 4'd10,
    AluSrlw = 4'd11,
    AluSraw = 4'd12
  } alu_operation_e;
endpackage

module alu_issue_stage
  import alu_issue_pkg::*;
#(
`ifdef BIT_COUNT_64
  parameter int unsigned XLEN = 64,
  parameter bit RV64 = 1'b1
`else
  parameter int unsigned XLEN = 32,
  parameter bit RV64 = 1'b0
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 DecValid,
  output logic                 DecReady,
  input  logic [6:0]           Opcode,
  input  logic [2:0]           Funct3,
  input  logic                 Funct7b5,
  input  logic [4:0]           Rs1Addr,
  input  logic [4:0]           Rs2Addr,
  input  logic [4:0]           RdAddr,
  input  logic [XLEN-1:0]      Rs1Data,
  input  logic [XLEN-1:0]      Rs2Data,
  input  logic [XLEN-1:0]      Imm,
  input  logic [XLEN-1:0]      PC,
  input  logic                 MemFwdValid,
  input  logic [4:0]           MemFwdRd,
  input  logic [XLEN-1:0]      MemFwdData,
  input  logic                 WbFwdValid,
  input  logic [4:0]           WbFwdRd,
  input  logic [XLEN-1:0]      WbFwdData,
  input  logic                 Flush,
  input  logic                 ExReady,
  output logic                 ExValid,
  output alu_operation_e       ALUOp,
  output logic [XLEN-1:0]      ALUOpA,
  output logic [XLEN-1:0]      ALUOpB,
  output logic [4:0]           ExRd,
  output logic                 WordOp,
  output logic                 IllegalOp
);

  localparam int unsigned ShamtW = $clog2(XLEN);

  localparam logic [6:0] OpcOp      = 7'b0110011;
  localparam logic [6:0] OpcOpImm   = 7'b0010011;
  localparam logic [6:0] OpcLui     = 7'b0110111;
  localparam logic [6:0] OpcAuipc   = 7'b0010111;
  localparam logic [6:0] OpcOp32    = 7'b0111011;
  localparam logic [6:0] OpcOpImm32 = 7'b0011011;

  // Shared funct3 table; alt selects SUB on 000 and SRA on 101.
  function automatic alu_operation_e funct3_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? AluSub : AluAdd;
      3'b001:  return AluSll;
      3'b010:  return AluSlt;
      3'b011:  return AluSltu;
      3'b100:  return AluXor;
      3'b101:  return alt ? AluSra : AluSrl;
      3'b110:  return AluOr;
      default: return AluAnd;
    endcase
  endfunction

  logic [XLEN-1:0] rs1_val, rs2_val;
  alu_operation_e  op_d;
  logic [XLEN-1:0] a_d, b_d;
  logic            word_d, illegal_d;

  logic            ex_valid_q;
  alu_operation_e  op_q;
  logic [XLEN-1:0] a_q, b_q;
  logic [4:0]      rd_q;
  logic            word_q, illegal_q;

  // Operand forwarding: Mem beats Wb, x0 always reads the register file.
  always_comb begin
    rs1_val = Rs1Data;
    if (Rs1Addr != 5'd0) begin
      if (MemFwdValid && (MemFwdRd == Rs1Addr))     rs1_val = MemFwdData;
      else if (WbFwdValid && (WbFwdRd == Rs1Addr))  rs1_val = WbFwdData;
    end
    rs2_val = Rs2Data;
    if (Rs2Addr != 5'd0) begin
      if (MemFwdValid && (MemFwdRd == Rs2Addr))     rs2_val = MemFwdData;
      else if (WbFwdValid && (WbFwdRd == Rs2Addr))  rs2_val = WbFwdData;
    end
  end

  // Opcode/funct decode into the next ALU bundle.
  always_comb begin
    op_d      = AluAdd;
    a_d       = rs1_val;
    b_d       = rs2_val;
    word_d    = 1'b0;
    illegal_d = 1'b0;
    case (Opcode)
      OpcOp: op_d = funct3_op(Funct3, Funct7b5);
      OpcOpImm: begin
        // Immediate forms have no SUBI; b5 only distinguishes SRAI.
        op_d = funct3_op(Funct3, Funct7b5 && (Funct3 == 3'b101));
        b_d  = Imm;
        if ((Funct3 == 3'b001) || (Funct3 == 3'b101)) b_d = XLEN'(Imm[ShamtW-1:0]);
      end
      OpcLui: begin
        a_d = '0;
        b_d = Imm;
      end
      OpcAuipc: begin
        a_d = PC;
        b_d = Imm;
      end
      OpcOp32, OpcOpImm32: begin
        word_d = 1'b1;
        if (Opcode == OpcOpImm32) b_d = (Funct3 == 3'b000) ? Imm : XLEN'(Imm[4:0]);
        case (Funct3)
          3'b000:  op_d = (Funct7b5 && (Opcode == OpcOp32)) ? AluSub : AluAdd;
          3'b001:  op_d = AluSllw;
          3'b101:  op_d = Funct7b5 ? AluSraw : AluSrlw;
          default: illegal_d = 1'b1;
        endcase
        if (!RV64) illegal_d = 1'b1;
      end
      default: illegal_d = 1'b1;
    endcase
    // Anything the ALU cannot execute issues as a harmless ADD 0,0.
    if (illegal_d) begin
      op_d   = AluAdd;
      a_d    = '0;
      b_d    = '0;
      word_d = 1'b0;
    end
  end

  assign DecReady = ~ex_valid_q | ExReady;

  // Issue register: flush beats capture, stall holds every bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid_q <= 1'b0;
      op_q       <= AluAdd;
      a_q        <= '0;
      b_q        <= '0;
      rd_q       <= 5'd0;
      word_q     <= 1'b0;
      illegal_q  <= 1'b0;
    end else if (Flush) begin
      ex_valid_q <= 1'b0;
    end else if (DecReady) begin
      ex_valid_q <= DecValid;
      if (DecValid) begin
        op_q      <= op_d;
        a_q       <= a_d;
        b_q       <= b_d;
        rd_q      <= RdAddr;
        word_q    <= word_d;
        illegal_q <= illegal_d;
      end
    end
  end

  assign ExValid   = ex_valid_q;
  assign ALUOp     = op_q;
  assign ALUOpA    = a_q;
  assign ALUOpB    = b_q;
  assign ExRd      = rd_q;
  assign WordOp    = word_q;
  assign IllegalOp = illegal_q;

endmodule
